// File: rtl/ibex_register_file_mp.sv
// Multi-port register file: R0 is hard-wired, two write ports (B over A), and a sequential scrub FSM.
// Optional macro IBEX_RF_BYPASS_EN compiles write-to-read forwarding into the read ports.
module ibex_register_file_mp #(
    parameter int unsigned           DataWidth   = 32,
    parameter int unsigned           AddrWidth   = 5,
    parameter int unsigned           NumRead     = 2,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumRead*AddrWidth-1:0]   raddr_i,
    output logic [NumRead*DataWidth-1:0]   rdata_o,
    input  logic [AddrWidth-1:0]           waddr_a_i,
    input  logic [DataWidth-1:0]           wdata_a_i,
    input  logic                           we_a_i,
    input  logic [AddrWidth-1:0]           waddr_b_i,
    input  logic [DataWidth-1:0]           wdata_b_i,
    input  logic                           we_b_i,
    input  logic                           clear_req_i,
    output logic                           clear_busy_o,
    output logic                           clear_done_o,
    output logic                           wr_drop_o,
    output logic                           err_o
);

    localparam int unsigned          NumWords = 2 ** AddrWidth;
    localparam logic [AddrWidth-1:0] IdxOne   = {{(AddrWidth-1){1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] IdxLast  = {AddrWidth{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [AddrWidth-1:0]   r_idx;
    logic [AddrWidth-1:0]   w_idx_nxt;
    logic                   w_clearing;

    logic [DataWidth-1:0]   r_mem     [1:NumWords-1];
    logic                   w_we_word [1:NumWords-1];
    logic [DataWidth-1:0]   w_wd_word [1:NumWords-1];
    logic [DataWidth-1:0]   w_rf      [NumWords];

    logic                   r_busy;
    logic                   r_done;
    logic                   r_wr_drop;
    logic                   r_err;

    assign w_clearing = (r_state == ST_CLEAR);

    // Scrub FSM state and index registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Scrub FSM next-state: the last index is all-ones, so CLEAR spans NumWords-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (clear_req_i) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = IdxOne;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_idx_nxt = r_idx + IdxOne;
                if (r_idx == IdxLast) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Per-word write decode: scrub owns the array in CLEAR, otherwise B wins over A.
    always_comb begin
        for (int i = 1; i < NumWords; i++) begin
            w_we_word[i] = 1'b0;
            w_wd_word[i] = wdata_a_i;
            if (w_clearing) begin
                if (r_idx == AddrWidth'(i)) begin
                    w_we_word[i] = 1'b1;
                    w_wd_word[i] = WordZeroVal;
                end else begin
                    w_we_word[i] = 1'b0;
                end
            end else if (we_b_i && (waddr_b_i == AddrWidth'(i))) begin
                w_we_word[i] = 1'b1;
                w_wd_word[i] = wdata_b_i;
            end else if (we_a_i && (waddr_a_i == AddrWidth'(i))) begin
                w_we_word[i] = 1'b1;
                w_wd_word[i] = wdata_a_i;
            end else begin
                w_we_word[i] = 1'b0;
            end
        end
    end

    // Register storage for words 1..NumWords-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i < NumWords; i++) begin
                r_mem[i] <= WordZeroVal;
            end
        end else begin
            for (int i = 1; i < NumWords; i++) begin
                if (w_we_word[i]) begin
                    r_mem[i] <= w_wd_word[i];
                end
            end
        end
    end

    // Flat read view with R0 tied to the constant.
    always_comb begin
        w_rf[0] = WordZeroVal;
        for (int i = 1; i < NumWords; i++) begin
            w_rf[i] = r_mem[i];
        end
    end

    for (genvar k = 0; k < NumRead; k++) begin : g_rd
        logic [AddrWidth-1:0] w_raddr;
        logic [DataWidth-1:0] w_rdata;

        assign w_raddr = raddr_i[k*AddrWidth +: AddrWidth];

        // Combinational read, optionally forwarding same-cycle write data outside CLEAR.
        always_comb begin
            w_rdata = w_rf[w_raddr];
`ifdef IBEX_RF_BYPASS_EN
            if (!w_clearing && (w_raddr != '0) && we_b_i && (waddr_b_i == w_raddr)) begin
                w_rdata = wdata_b_i;
            end else if (!w_clearing && (w_raddr != '0) && we_a_i && (waddr_a_i == w_raddr)) begin
                w_rdata = wdata_a_i;
            end else begin
                w_rdata = w_rf[w_raddr];
            end
`endif
        end

        assign rdata_o[k*DataWidth +: DataWidth] = w_rdata;
    end

    // Registered status flags, aligned with the FSM state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_drop <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt == ST_CLEAR);
            r_done    <= (w_state_nxt == ST_DONE);
            r_wr_drop <= w_clearing && (we_a_i || we_b_i);
            r_err     <= !w_clearing && we_a_i && we_b_i &&
                         (waddr_a_i == waddr_b_i) && (waddr_a_i != '0);
        end
    end

    assign clear_busy_o = r_busy;
    assign clear_done_o = r_done;
    assign wr_drop_o    = r_wr_drop;
    assign err_o        = r_err;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Scoreboard bench for ibex_register_file_mp (default parameters, 32 words x 32 bits, 2 read ports).
module tb_ibex_register_file_mp;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [9:0]  raddr_i = '0;
    logic [63:0] rdata_o;
    logic [4:0]  waddr_a_i = '0;
    logic [31:0] wdata_a_i = '0;
    logic        we_a_i = 1'b0;
    logic [4:0]  waddr_b_i = '0;
    logic [31:0] wdata_b_i = '0;
    logic        we_b_i = 1'b0;
    logic        clear_req_i = 1'b0;
    logic        clear_busy_o, clear_done_o, wr_drop_o, err_o;

    typedef struct {
        int          port;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    logic [31:0] mdl [32];
    int          n_vec = 0;
    int          n_err = 0;

    ibex_register_file_mp dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .waddr_a_i    (waddr_a_i),
        .wdata_a_i    (wdata_a_i),
        .we_a_i       (we_a_i),
        .waddr_b_i    (waddr_b_i),
        .wdata_b_i    (wdata_b_i),
        .we_b_i       (we_b_i),
        .clear_req_i  (clear_req_i),
        .clear_busy_o (clear_busy_o),
        .clear_done_o (clear_done_o),
        .wr_drop_o    (wr_drop_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd_exp(input int port, input int addr, input logic [31:0] exp, input string tag);
        rd_exp_t e;
        logic [4:0] a;
        a = 5'(addr);
        raddr_i[port*5 +: 5] = a;
        sb_q.push_back('{port, exp});
        #1;
        e = sb_q.pop_front();
        chk(tag, rdata_o[e.port*32 +: 32], e.val);
    endtask

    task automatic rd(input int port, input int addr, input string tag);
        rd_exp(port, addr, mdl[addr], tag);
    endtask

    task automatic write_a(input int addr, input logic [31:0] data);
        waddr_a_i = 5'(addr);
        wdata_a_i = data;
        we_a_i    = 1'b1;
        tick();
        we_a_i = 1'b0;
        if (addr != 0) mdl[addr] = data;
    endtask

    task automatic fill_all(input logic [31:0] base);
        for (int i = 1; i < 32; i++) write_a(i, base + 32'(i) * 32'h0101_0101);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [31:0] byp_exp;

        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // reset state
        #12;
        chk("rst_busy", {31'd0, clear_busy_o}, 32'd0);
        chk("rst_done", {31'd0, clear_done_o}, 32'd0);
        chk("rst_drop", {31'd0, wr_drop_o}, 32'd0);
        chk("rst_err",  {31'd0, err_o}, 32'd0);
        rd(0, 5, "rst_rd5");
        rst_i = 1'b0;
        tick();

        // basic write/read and R0
        write_a(3, 32'hDEAD_BEEF);
        rd(0, 3, "rd3");
        rd(1, 0, "rd0");
        write_a(0, 32'hFFFF_FFFF);
        rd(0, 0, "r0_ignored");

        // same-address collision: B wins, err pulses once
        waddr_a_i = 5'd7; wdata_a_i = 32'h11; we_a_i = 1'b1;
        waddr_b_i = 5'd7; wdata_b_i = 32'h22; we_b_i = 1'b1;
        tick();
        we_a_i = 1'b0; we_b_i = 1'b0;
        mdl[7] = 32'h22;
        chk("err_pulse", {31'd0, err_o}, 32'd1);
        rd(1, 7, "rd7_b_wins");
        tick();
        chk("err_clear", {31'd0, err_o}, 32'd0);

        // different addresses both land, no err
        waddr_a_i = 5'd8; wdata_a_i = 32'h88; we_a_i = 1'b1;
        waddr_b_i = 5'd9; wdata_b_i = 32'h99; we_b_i = 1'b1;
        tick();
        we_a_i = 1'b0; we_b_i = 1'b0;
        mdl[8] = 32'h88; mdl[9] = 32'h99;
        chk("err_diff", {31'd0, err_o}, 32'd0);
        rd(0, 8, "rd8");
        rd(1, 9, "rd9");

        // same-cycle write/read of addr 5
        write_a(5, 32'h0000_5555);
        waddr_b_i = 5'd5; wdata_b_i = 32'hA5A5_A5A5; we_b_i = 1'b1;
`ifdef IBEX_RF_BYPASS_EN
        byp_exp = 32'hA5A5_A5A5;
`else
        byp_exp = 32'h0000_5555;
`endif
        rd_exp(1, 5, byp_exp, "rd5_same_cycle");
        tick();
        we_b_i = 1'b0;
        mdl[5] = 32'hA5A5_A5A5;
        rd(1, 5, "rd5_after");

        // full scrub with a dropped write
        fill_all(32'h1000_0000);
        rd(0, 31, "fill31");
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clear_busy_o) busy_cnt++;
            if (clear_done_o) done_cnt++;
            if (c == 0) begin
                rd(1, 20, "scrub_old20");
                waddr_a_i = 5'd4; wdata_a_i = 32'h1234; we_a_i = 1'b1;
            end
            if (c == 1) begin
                chk("drop_pulse", {31'd0, wr_drop_o}, 32'd1);
                we_a_i = 1'b0;
            end
            if (c == 2) chk("drop_clear", {31'd0, wr_drop_o}, 32'd0);
            tick();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd31);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 32; i++) rd(i % 2, i, "scrubbed");

        // reset in the middle of a scrub
        fill_all(32'h2000_0000);
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        rst_i = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rd(0, 25, "rst_mid_rd25");
        rd(1, 12, "rst_mid_rd12");
        chk("rst_mid_busy", {31'd0, clear_busy_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (clear_done_o) done_cnt++;
            if (clear_busy_o) busy_cnt++;
            tick();
        end
        chk("rst_mid_nodone", 32'(done_cnt), 32'd0);
        chk("rst_mid_nobusy", 32'(busy_cnt), 32'd0);
        write_a(6, 32'hCAFE_F00D);
        rd(0, 6, "post_rst_rd6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
